// File: rtl/sys_ctrl_pkg.sv
// Shared system-controller constants: default widths, configuration
// register reset values and the register map of the low registers.
package sys_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    // UART config: parity enable, even parity, prescale 32.
    localparam logic [7:0] UART_CFG_RST  = 8'h81;
    // Clock-divider ratio 32.
    localparam logic [7:0] DIV_RATIO_RST = 8'h20;

    localparam int REG_ALU_A     = 0;
    localparam int REG_ALU_B     = 1;
    localparam int REG_UART_CFG  = 2;
    localparam int REG_DIV_RATIO = 3;

endpackage

// File: rtl/cfg_tap_pack.sv
// Flattens the lowest NUM_CFG register words onto one packed bus,
// register k landing at bits [k*DATA_WIDTH +: DATA_WIDTH]. Pure wiring,
// so the bus is driven straight from the storage flops.
module cfg_tap_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CFG    = 4
) (
    input  logic [NUM_CFG-1:0][DATA_WIDTH-1:0] regs,
    output logic [NUM_CFG*DATA_WIDTH-1:0]      cfg_regs
);

    // Place each configuration word in its own lane of the output bus.
    always_comb begin
        cfg_regs = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            cfg_regs[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
        end
    end

endmodule

// File: rtl/reg_file_cfg.sv
// Single-port register file for the system controller. Holds operands
// and configuration words, answers reads with a registered one-cycle
// valid strobe, and exports its lowest NUM_CFG words continuously.
//
// Handshake: the controller asserts RdEn for one cycle per word it wants;
// there is no ready/back-pressure. RdData_Valid is high for exactly the
// cycle after each accepted read. A write in the same cycle wins and the
// read is dropped without a strobe; the controller must reissue it.
module reg_file_cfg
    import sys_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    NUM_CFG    = 4,
    parameter logic [DATA_WIDTH-1:0] CFG2_RST   = DATA_WIDTH'(UART_CFG_RST),
    parameter logic [DATA_WIDTH-1:0] CFG3_RST   = DATA_WIDTH'(DIV_RATIO_RST)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          WrEn,
    input  logic                          RdEn,
    input  logic [ADDR_WIDTH-1:0]         Address,
    input  logic [DATA_WIDTH-1:0]         WrData,
    output logic [DATA_WIDTH-1:0]         RdData,
    output logic                          RdData_Valid,
    output logic [NUM_CFG*DATA_WIDTH-1:0] Cfg_Regs
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Packed so the configuration slice can be handed over as one vector.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    logic rd_accept;

    // Reset value per register; only indices below DEPTH are ever asked,
    // so registers 2/3 get their presets only when they exist.
    function automatic logic [DATA_WIDTH-1:0] rst_value(input int idx);
        rst_value = '0;
        if (idx == REG_UART_CFG) begin
            rst_value = CFG2_RST;
        end else if (idx == REG_DIV_RATIO) begin
            rst_value = CFG3_RST;
        end
    endfunction

    assign rd_accept = RdEn && !WrEn;

    // Storage: preset on reset, otherwise take a write at the edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= rst_value(i);
            end
        end else if (WrEn) begin
            mem[Address] <= WrData;
        end
    end

    // Read port: capture data on an accepted read, strobe valid for one cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RdData       <= '0;
            RdData_Valid <= 1'b0;
        end else begin
            RdData_Valid <= rd_accept;
            if (rd_accept) begin
                RdData <= mem[Address];
            end
        end
    end

    cfg_tap_pack #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CFG    (NUM_CFG)
    ) u_cfg_tap_pack (
        .regs     (mem[NUM_CFG-1:0]),
        .cfg_regs (Cfg_Regs)
    );

endmodule

// File: tb/tb_reg_file_cfg.sv
// Bench for reg_file_cfg: a default-parameter instance driven by a vector
// table, hand-written reset/parameter sequences and random traffic checked
// against an array model; plus a 16-bit/8-deep/2-tap instance.
module tb_reg_file_cfg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        wr_en, rd_en;
    logic [3:0]  address;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [31:0] cfg_regs;

    // swept instance
    logic        s_wr_en, s_rd_en;
    logic [2:0]  s_address;
    logic [15:0] s_wr_data;
    logic [15:0] s_rd_data;
    logic        s_rd_valid;
    logic [31:0] s_cfg_regs;

    int tests = 0;
    int fails = 0;

    reg_file_cfg dut (
        .CLK          (clk),
        .RST          (rst_n),
        .WrEn         (wr_en),
        .RdEn         (rd_en),
        .Address      (address),
        .WrData       (wr_data),
        .RdData       (rd_data),
        .RdData_Valid (rd_valid),
        .Cfg_Regs     (cfg_regs)
    );

    reg_file_cfg #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (3),
        .NUM_CFG    (2)
    ) dut_sweep (
        .CLK          (clk),
        .RST          (rst_n),
        .WrEn         (s_wr_en),
        .RdEn         (s_rd_en),
        .Address      (s_address),
        .WrData       (s_wr_data),
        .RdData       (s_rd_data),
        .RdData_Valid (s_rd_valid),
        .Cfg_Regs     (s_cfg_regs)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // 1 time unit after the edge that consumes them.
    task automatic drive(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        address = a;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic w, input logic r, input logic [2:0] a, input logic [15:0] d);
        s_wr_en   = w;
        s_rd_en   = r;
        s_address = a;
        s_wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;     // released mid-cycle, taken at the next rising edge
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        w;
        logic        r;
        logic [3:0]  a;
        logic [7:0]  d;
        logic        exp_valid;
        logic [7:0]  exp_rd;
        logic [31:0] exp_cfg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic w, input logic r, input logic [3:0] a,
                                input logic [7:0] d, input logic ev, input logic [7:0] er,
                                input logic [31:0] ec);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d;
        v.exp_valid = ev; v.exp_rd = er; v.exp_cfg = ec;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  model_mem [16];
    logic [7:0]  model_rd;
    logic        model_valid;

    function automatic logic [31:0] model_cfg();
        return {model_mem[3], model_mem[2], model_mem[1], model_mem[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_mem[2] = 8'h81;
        model_mem[3] = 8'h20;
        model_rd     = 8'h00;
        model_valid  = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        wr_en = 0; rd_en = 0; address = 0; wr_data = 0;
        s_wr_en = 0; s_rd_en = 0; s_address = 0; s_wr_data = 0;

        do_reset();
        check("post_reset_rd", {24'h0, rd_data}, 32'h0);
        check("post_reset_valid", {31'h0, rd_valid}, 32'h0);
        check("post_reset_cfg", cfg_regs, 32'h2081_0000);

        // Reset asserted while a read strobe is up: outputs clear with no edge.
        drive(1'b1, 1'b0, 4'd2, 8'h11);
        drive(1'b0, 1'b1, 4'd2, 8'h00);
        check("pre_async_valid", {31'h0, rd_valid}, 32'h1);
        check("pre_async_rd", {24'h0, rd_data}, 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, rd_valid}, 32'h0);
        check("async_rst_rd", {24'h0, rd_data}, 32'h0);
        check("async_rst_cfg", cfg_regs, 32'h2081_0000);
        wr_en = 0; rd_en = 0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: reset contents, write/read, collision, config tap, streaming.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] ev;
            ev = (i == 2) ? 8'h81 : (i == 3) ? 8'h20 : 8'h00;
            vecs.push_back(mk(1'b0, 1'b1, 4'(i), 8'h00, 1'b1, ev, 32'h2081_0000));
        end
        vecs.push_back(mk(1'b1, 1'b0, 4'd5, 8'h5A, 1'b0, 8'h00, 32'h2081_0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'd5, 8'h00, 1'b1, 8'h5A, 32'h2081_0000));
        vecs.push_back(mk(1'b0, 1'b0, 4'd5, 8'h00, 1'b0, 8'h5A, 32'h2081_0000));
        vecs.push_back(mk(1'b1, 1'b1, 4'd7, 8'h3C, 1'b0, 8'h5A, 32'h2081_0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'd7, 8'h00, 1'b1, 8'h3C, 32'h2081_0000));
        vecs.push_back(mk(1'b1, 1'b0, 4'd1, 8'hA5, 1'b0, 8'h3C, 32'h2081_A500));
        vecs.push_back(mk(1'b1, 1'b0, 4'd9, 8'h77, 1'b0, 8'h3C, 32'h2081_A500));
        vecs.push_back(mk(1'b0, 1'b1, 4'd0, 8'h00, 1'b1, 8'h00, 32'h2081_A500));
        vecs.push_back(mk(1'b0, 1'b1, 4'd1, 8'h00, 1'b1, 8'hA5, 32'h2081_A500));
        vecs.push_back(mk(1'b0, 1'b1, 4'd2, 8'h00, 1'b1, 8'h81, 32'h2081_A500));
        vecs.push_back(mk(1'b0, 1'b1, 4'd3, 8'h00, 1'b1, 8'h20, 32'h2081_A500));
        vecs.push_back(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h20, 32'h2081_A500));
        vecs.push_back(mk(1'b0, 1'b1, 4'd9, 8'h00, 1'b1, 8'h77, 32'h2081_A500));
        vecs.push_back(mk(1'b1, 1'b0, 4'd3, 8'h05, 1'b0, 8'h77, 32'h0581_A500));
        vecs.push_back(mk(1'b0, 1'b1, 4'd3, 8'h00, 1'b1, 8'h05, 32'h0581_A500));

        foreach (vecs[i]) begin
            drive(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d_valid", i), {31'h0, rd_valid}, {31'h0, vecs[i].exp_valid});
            check($sformatf("vec%0d_rd", i), {24'h0, rd_data}, {24'h0, vecs[i].exp_rd});
            check($sformatf("vec%0d_cfg", i), cfg_regs, vecs[i].exp_cfg);
        end

        // Random traffic against the array model.
        drive(1'b0, 1'b0, 4'd0, 8'h00);
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            logic       w, r;
            logic [3:0] a;
            logic [7:0] d;
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 1);
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            drive(w, r, a, d);
            if (w) begin
                model_mem[a] = d;
                model_valid  = 1'b0;
            end else if (r) begin
                model_rd    = model_mem[a];
                model_valid = 1'b1;
            end else begin
                model_valid = 1'b0;
            end
            check("rand_valid", {31'h0, rd_valid}, {31'h0, model_valid});
            check("rand_rd", {24'h0, rd_data}, {24'h0, model_rd});
            check("rand_cfg", cfg_regs, model_cfg());
        end
        drive(1'b0, 1'b0, 4'd0, 8'h00);

        // Swept instance: 16-bit words, 8 registers, 2 configuration taps.
        do_reset();
        check("sweep_reset_cfg", s_cfg_regs, 32'h0000_0000);
        drive_s(1'b0, 1'b1, 3'd2, 16'h0);
        check("sweep_reg2_rst", {16'h0, s_rd_data}, 32'h0081);
        drive_s(1'b0, 1'b1, 3'd3, 16'h0);
        check("sweep_reg3_rst", {16'h0, s_rd_data}, 32'h0020);
        drive_s(1'b1, 1'b0, 3'd7, 16'hBEEF);
        check("sweep_wr_valid", {31'h0, s_rd_valid}, 32'h0);
        drive_s(1'b0, 1'b1, 3'd7, 16'h0);
        check("sweep_top_rd", {16'h0, s_rd_data}, 32'hBEEF);
        check("sweep_top_valid", {31'h0, s_rd_valid}, 32'h1);
        drive_s(1'b1, 1'b0, 3'd1, 16'h1234);
        check("sweep_cfg_tap1", s_cfg_regs, 32'h1234_0000);
        drive_s(1'b1, 1'b0, 3'd0, 16'hCAFE);
        check("sweep_cfg_tap0", s_cfg_regs, 32'h1234_CAFE);
        drive_s(1'b1, 1'b0, 3'd2, 16'h9999);
        check("sweep_cfg_untapped", s_cfg_regs, 32'h1234_CAFE);
        drive_s(1'b0, 1'b0, 3'd0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
